score_argmax: RTL

SCORE_ARGMAX -- requirements
Module: score_argmax

---
 rtl/score_argmax.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/score_argmax.sv
// ---------------------------------------------------------------------------
// score_argmax
//
// Scans a stream of popcount scores from the bit counter and keeps the best
// score, its associative-memory address and the runner-up score. This lets
// the classifier report the winning class and a confidence margin.
// Max mode picks the highest similarity. Min mode picks the lowest Hamming
// distance.
//
// Ports
//   clk_i          in   clock
//   rst_i          in   synchronous active-high reset
//   start_i        in   pulse: begin a new search (aborts any search in flight)
//   mode_min_i     in   sampled with start_i: 1 = minimum, 0 = maximum
//   score_valid_i  in   score_i/addr_i valid this cycle
//   score_i        in   popcount score (SW bits)
//   addr_i         in   AM address the score belongs to
//   busy_o         out  high while searching
//   done_o         out  one-cycle pulse when the result is final
//   best_addr_o    out  address of the winning score
//   best_score_o   out  winning score
//   margin_o       out  |best - second best|
//   count_o        out  scores accepted in the current/last search
// ---------------------------------------------------------------------------
module score_argmax #(
  parameter  int N             = 2048,
  parameter  int AM_ADDR_WIDTH = 13,
  parameter  int NUM_CLASSES   = 26,
  localparam int SW            = $clog2(N + 1),
  localparam int CW            = $clog2(NUM_CLASSES + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic                     mode_min_i,
  input  logic                     score_valid_i,
  input  logic [SW-1:0]            score_i,
  input  logic [AM_ADDR_WIDTH-1:0] addr_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [AM_ADDR_WIDTH-1:0] best_addr_o,
  output logic [SW-1:0]            best_score_o,
  output logic [SW-1:0]            margin_o,
  output logic [CW-1:0]            count_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEARCH,
    S_DONE
  } state_t;

  state_t                   r_state;
  state_t                   w_stateNext;
  logic                     r_modeMin;
  logic [SW-1:0]            r_best;
  logic [SW-1:0]            r_second;
  logic [AM_ADDR_WIDTH-1:0] r_bestAddr;
  logic [CW-1:0]            r_count;

  logic                     w_accept;
  logic                     w_lastScore;
  logic                     w_firstScore;
  logic                     w_beatsBest;
  logic                     w_beatsSecond;
  logic [SW-1:0]            w_initVal;
  logic [SW-1:0]            w_margin;

  // A score only counts while searching. A coincident start_i throws the
  // score away, because the new search must begin from a clean slate.
  assign w_accept     = (r_state == S_SEARCH) && score_valid_i && !start_i;
  assign w_lastScore  = (r_count == CW'(NUM_CLASSES - 1));
  assign w_firstScore = (r_count == '0);

  // The "worst possible" seed is 0 for max mode and N for min mode.
  // Either score in 0..N can then displace it.
  assign w_initVal = mode_min_i ? SW'(N) : '0;

  // Strict comparison against best, so an equal score keeps the address that
  // arrived earlier. Against second, an equal score is allowed in, so that
  // duplicate scores give a margin of zero.
  assign w_beatsBest   = r_modeMin ? (score_i <  r_best)   : (score_i >  r_best);
  assign w_beatsSecond = r_modeMin ? (score_i <= r_second) : (score_i >= r_second);

  // second never beats best, so this subtraction cannot wrap.
  assign w_margin = r_modeMin ? (r_second - r_best) : (r_best - r_second);

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state and status decode. start_i takes priority in every state,
  // so a search can be restarted or aborted at any time.
  always_comb begin
    w_stateNext = r_state;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_stateNext = S_IDLE;
      end
      S_SEARCH: begin
        busy_o = 1'b1;
        if (w_accept && w_lastScore) begin
          w_stateNext = S_DONE;
        end
      end
      S_DONE: begin
        done_o      = 1'b1;
        w_stateNext = S_IDLE;
      end
      default: begin
        w_stateNext = S_IDLE;
      end
    endcase
    if (start_i) begin
      w_stateNext = S_SEARCH;
    end
  end

  // Running best/second tracker. The first accepted score always takes the
  // best slot. The seeded second value stays in place so that the margin
  // reads against the worst value until a real runner-up arrives.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_modeMin  <= 1'b0;
      r_best     <= '0;
      r_second   <= '0;
      r_bestAddr <= '0;
      r_count    <= '0;
    end else if (start_i) begin
      r_modeMin  <= mode_min_i;
      r_best     <= w_initVal;
      r_second   <= w_initVal;
      r_bestAddr <= '0;
      r_count    <= '0;
    end else if (w_accept) begin
      r_count <= r_count + CW'(1);
      if (w_firstScore) begin
        r_best     <= score_i;
        r_bestAddr <= addr_i;
      end else if (w_beatsBest) begin
        r_second   <= r_best;
        r_best     <= score_i;
        r_bestAddr <= addr_i;
      end else if (w_beatsSecond) begin
        r_second <= score_i;
      end
    end
  end

  assign best_addr_o  = r_bestAddr;
  assign best_score_o = r_best;
  assign count_o      = r_count;
  // With a single class there is no runner-up, so the margin is meaningless.
  assign margin_o     = (NUM_CLASSES == 1) ? '0 : w_margin;

endmodule
